// File: rtl/cpu_mem_pkg.sv
// Shared memory-side types for the CPU: arbiter state encoding,
// requester IDs and default RAM geometry.
package cpu_mem_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_F = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to
// whichever side was not granted last.
module rr_pick2
  import cpu_mem_pkg::*;
(
  input  logic    f_req,
  input  logic    d_req,
  input  req_id_t last_grant,
  output req_id_t grant
);

  always_comb begin
    grant = REQ_F;
    unique case (1'b1)
      f_req && d_req:
        grant = (last_grant == REQ_F) ? REQ_D : REQ_F;
      d_req && !f_req:
        grant = REQ_D;
      default:
        grant = REQ_F;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Serialises fetch and data accesses onto the single-port RAM,
// absorbing the RAM read latency and pulsing a per-port ack.
module ram_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_ack,
  output logic [DW-1:0] f_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy
);

  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  arb_state_t state;
  req_id_t    last_grant;
  req_id_t    cur_id;
  req_id_t    pick;
  logic       cur_we;
  logic [1:0] cnt;

  rr_pick2 u_pick (
    .f_req      (f_req),
    .d_req      (d_req),
    .last_grant (last_grant),
    .grant      (pick)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= REQ_D;
      cur_id     <= REQ_F;
      cur_we     <= 1'b0;
      cnt        <= '0;
      f_ack      <= 1'b0;
      d_ack      <= 1'b0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      f_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      f_ack  <= 1'b0;
      d_ack  <= 1'b0;
      ram_en <= 1'b0;
      ram_we <= 1'b0;
      unique case (state)
        IDLE: begin
          if (f_req || d_req) begin
            cur_id     <= pick;
            last_grant <= pick;
            cur_we     <= (pick == REQ_D) && d_we;
            ram_en     <= 1'b1;
            ram_we     <= (pick == REQ_D) && d_we;
            if (pick == REQ_D) begin
              ram_addr  <= d_addr;
              ram_wdata <= d_wdata;
            end else begin
              ram_addr  <= f_addr;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          cnt <= CNT_INIT;
          if (cur_we) begin
            d_ack <= 1'b1;
            state <= ACK;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          // cnt==0 marks the cycle ram_rdata is valid
          if (cnt == '0) begin
            if (cur_id == REQ_D) begin
              d_rdata <= ram_rdata;
              d_ack   <= 1'b1;
            end else begin
              f_rdata <= ram_rdata;
              f_ack   <= 1'b1;
            end
            state <= ACK;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        ACK: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Random + directed bench for ram_arbiter at RD_LAT=1 and RD_LAT=3,
// checked against a transaction-timeline reference model.
module tb_ram_arbiter;
  import cpu_mem_pkg::*;

  localparam int AW = 8;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst, f_req, d_req, d_we;
  logic [1:0] f_ack, d_ack, ram_en, ram_we, busy;
  logic [AW-1:0] f_addr [2];
  logic [AW-1:0] d_addr [2];
  logic [AW-1:0] ram_addr [2];
  logic [DW-1:0] d_wdata [2];
  logic [DW-1:0] f_rdata [2];
  logic [DW-1:0] d_rdata [2];
  logic [DW-1:0] ram_wdata [2];
  logic [DW-1:0] ram_rdata [2];

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] ref_mem [2][256];
  logic [DW-1:0] exp_f [2];
  logic [DW-1:0] exp_d [2];
  bit lg [2];

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 16) return 16'hA5A5;
    return {8'(i) ^ 8'hC3, 8'(i)};
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : 3;
    logic [DW-1:0] mem [256];
    logic [255:0] wv = '0;
    logic [AW-1:0] pa [4];
    logic [3:0] pv = '0;

    ram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(L)) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .f_req     (f_req[g]),
      .f_addr    (f_addr[g]),
      .f_ack     (f_ack[g]),
      .f_rdata   (f_rdata[g]),
      .d_req     (d_req[g]),
      .d_we      (d_we[g]),
      .d_addr    (d_addr[g]),
      .d_wdata   (d_wdata[g]),
      .d_ack     (d_ack[g]),
      .d_rdata   (d_rdata[g]),
      .ram_en    (ram_en[g]),
      .ram_we    (ram_we[g]),
      .ram_addr  (ram_addr[g]),
      .ram_wdata (ram_wdata[g]),
      .ram_rdata (ram_rdata[g]),
      .busy      (busy[g])
    );

    // RAM whose data appears L cycles after the ram_en cycle
    always @(posedge clk) begin
      if (ram_en[g] && ram_we[g]) begin
        mem[ram_addr[g]] <= ram_wdata[g];
        wv[ram_addr[g]]  <= 1'b1;
      end
      pv    <= {pv[2:0], ram_en[g] & ~ram_we[g]};
      pa[0] <= ram_addr[g];
      pa[1] <= pa[0];
      pa[2] <= pa[1];
      pa[3] <= pa[2];
    end

    assign ram_rdata[g] = !pv[L-1] ? 16'hDEAD :
                          wv[pa[L-1]] ? mem[pa[L-1]] :
                          init_word(int'(pa[L-1]));
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One arbitration round: expected schedule computed up front.
  task automatic run_txn(input int k, input bit fr, input bit dr,
                         input bit dwe, input logic [AW-1:0] fa,
                         input logic [AW-1:0] da,
                         input logic [DW-1:0] dwd, input bit chg);
    bit port [2];
    bit we [2];
    logic [AW-1:0] ad [2];
    int st [2];
    int ak [2];
    int n, ai;
    bit act, fa_e, da_e, iss;
    string tg;
    n = 0;
    if (fr && dr) begin
      port[0] = !lg[k];
      port[1] = lg[k];
      n = 2;
    end else if (fr || dr) begin
      port[0] = dr;
      n = 1;
    end
    if (n == 0) return;
    st[0] = 0;
    for (int i = 0; i < n; i++) begin
      ad[i] = port[i] ? da : fa;
      we[i] = port[i] && dwe;
      ak[i] = st[i] + (we[i] ? 2 : 2 + lat_of(k));
      if (i == 0) st[1] = ak[0] + 1;
    end
    lg[k] = port[n-1];
    f_req[k] = fr;
    f_addr[k] = fa;
    d_req[k] = dr;
    d_we[k] = dwe;
    d_addr[k] = da;
    d_wdata[k] = dwd;
    for (int c = 1; c <= ak[n-1] + 1; c++) begin
      @(negedge clk);
      act = 0;
      ai = 0;
      fa_e = 0;
      da_e = 0;
      for (int i = 0; i < n; i++)
        if (c > st[i] && c <= ak[i]) begin
          act = 1;
          ai = i;
        end
      iss = act && (c == st[ai] + 1);
      if (iss && we[ai]) ref_mem[k][ad[ai]] = dwd;
      for (int i = 0; i < n; i++)
        if (c == ak[i]) begin
          if (port[i]) begin
            da_e = 1;
            if (!we[i]) exp_d[k] = ref_mem[k][ad[i]];
          end else begin
            fa_e = 1;
            exp_f[k] = ref_mem[k][ad[i]];
          end
        end
      tg = $sformatf("k%0d c%0d", k, c);
      chk({tg, " busy"}, busy[k], act);
      chk({tg, " ram_en"}, ram_en[k], iss);
      chk({tg, " ram_we"}, ram_we[k], iss && we[ai]);
      if (act) chk({tg, " ram_addr"}, ram_addr[k], ad[ai]);
      if (iss && we[ai]) chk({tg, " ram_wdata"}, ram_wdata[k], dwd);
      chk({tg, " f_ack"}, f_ack[k], fa_e);
      chk({tg, " d_ack"}, d_ack[k], da_e);
      chk({tg, " f_rdata"}, f_rdata[k], exp_f[k]);
      chk({tg, " d_rdata"}, d_rdata[k], exp_d[k]);
      if (fa_e) f_req[k] = 1'b0;
      if (da_e) d_req[k] = 1'b0;
      if (chg && c == 1) d_addr[k] = da + 8'd1;
    end
  endtask

  task automatic rand_txns(input int k, input int num);
    int p;
    for (int i = 0; i < num; i++) begin
      p = int'($urandom_range(1, 3));
      run_txn(k, p[0], p[1], 1'($urandom % 2),
              8'($urandom_range(0, 31)), 8'($urandom_range(0, 31)),
              16'($urandom), 1'b0);
    end
  endtask

  task automatic check_reset(input int k, input string tag);
    chk({tag, " busy"}, busy[k], 1'b0);
    chk({tag, " f_ack"}, f_ack[k], 1'b0);
    chk({tag, " d_ack"}, d_ack[k], 1'b0);
    chk({tag, " ram_en"}, ram_en[k], 1'b0);
    chk({tag, " ram_we"}, ram_we[k], 1'b0);
    chk({tag, " ram_addr"}, ram_addr[k], '0);
    chk({tag, " ram_wdata"}, ram_wdata[k], '0);
    chk({tag, " f_rdata"}, f_rdata[k], '0);
    chk({tag, " d_rdata"}, d_rdata[k], '0);
  endtask

  task automatic mid_reset(input int k);
    f_req[k] = 1'b0;
    d_req[k] = 1'b1;
    d_we[k] = 1'b0;
    d_addr[k] = 8'h40;
    repeat (2) @(negedge clk);
    chk("midrst wait busy", busy[k], 1'b1);
    rst[k] = 1'b1;
    d_req[k] = 1'b0;
    @(negedge clk);
    check_reset(k, "midrst");
    rst[k] = 1'b0;
    exp_f[k] = '0;
    exp_d[k] = '0;
    lg[k] = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("midrst no d_ack", d_ack[k], 1'b0);
      chk("midrst idle", busy[k], 1'b0);
    end
  endtask

  initial begin
    rst = '1;
    f_req = '0;
    d_req = '0;
    d_we = '0;
    for (int k = 0; k < 2; k++) begin
      f_addr[k] = '0;
      d_addr[k] = '0;
      d_wdata[k] = '0;
      exp_f[k] = '0;
      exp_d[k] = '0;
      lg[k] = 1'b1;
      for (int i = 0; i < 256; i++) ref_mem[k][i] = init_word(i);
    end
    repeat (3) @(negedge clk);
    rst = '0;
    @(negedge clk);
    check_reset(0, "reset k0");
    check_reset(1, "reset k1");

    run_txn(0, 1, 0, 0, 8'h10, 8'h00, 16'h0000, 0);
    run_txn(0, 0, 1, 1, 8'h00, 8'h20, 16'h1234, 0);
    run_txn(0, 0, 1, 0, 8'h00, 8'h20, 16'h0000, 0);
    run_txn(0, 1, 1, 0, 8'h11, 8'h21, 16'h0000, 0);
    run_txn(0, 1, 0, 0, 8'h12, 8'h00, 16'h0000, 0);
    run_txn(0, 1, 1, 1, 8'h13, 8'h13, 16'hBEEF, 0);
    run_txn(0, 1, 1, 0, 8'h14, 8'h13, 16'h0000, 0);
    run_txn(0, 0, 1, 0, 8'h00, 8'h30, 16'h0000, 1);
    run_txn(0, 0, 1, 1, 8'h00, 8'h30, 16'h5678, 1);
    rand_txns(0, 40);

    run_txn(1, 1, 0, 0, 8'h05, 8'h00, 16'h0000, 0);
    rand_txns(1, 40);
    run_txn(1, 0, 1, 0, 8'h00, 8'h07, 16'h0000, 0);
    mid_reset(1);
    run_txn(1, 1, 1, 0, 8'h08, 8'h09, 16'h0000, 0);
    rand_txns(1, 10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
